// File: rtl/radar_sample_framer.sv
// Multi-channel radar capture framer: enable-windowed sample capture with programmable
// start/stop latency, FRST/LAST marker words, optional alignment padding, FWFT FIFO to AXIS.

module radar_lane_mux #(
  parameter int NUM_CH = 2,
  parameter int SEL_W  = 2
) (
  input  logic [SEL_W-1:0]    i_sel,
  input  logic [NUM_CH*32-1:0] i_ch_data,
  input  logic [31:0]         i_sample_cnt,
  input  logic [31:0]         i_gcnt,
  output logic [31:0]         o_lane
);
  localparam logic [SEL_W-1:0] SEL_SCNT = SEL_W'(NUM_CH);
  localparam logic [SEL_W-1:0] SEL_GCNT = SEL_W'(NUM_CH + 1);

  // Selector values beyond the counters yield zero.
  always_comb begin
    o_lane = '0;
    for (int k = 0; k < NUM_CH; k++)
      if (i_sel == SEL_W'(k)) o_lane = i_ch_data[32*k +: 32];
    if (i_sel == SEL_SCNT) o_lane = i_sample_cnt;
    if (i_sel == SEL_GCNT) o_lane = i_gcnt;
  end
endmodule

module radar_sample_framer #(
  parameter  int NUM_CH          = 2,
  parameter  int ALIGN_LOG2      = 6,
  parameter  int LAT_W           = 8,
  parameter  int FIFO_DEPTH_LOG2 = 9,
  localparam int SEL_W           = $clog2(NUM_CH + 2)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_CH*32-1:0] ch_data,
  input  logic                 ch_valid,
  input  logic                 enable,
  input  logic [LAT_W-1:0]     start_delay,
  input  logic [LAT_W-1:0]     stop_delay,
  input  logic [SEL_W-1:0]     route_sel_u,
  input  logic [SEL_W-1:0]     route_sel_l,
  input  logic                 pad_enable,
  input  logic                 overflow_clr,
  output logic [63:0]          m_tdata,
  output logic                 m_tvalid,
  output logic                 m_tlast,
  output logic                 m_tuser,
  input  logic                 m_tready,
  output logic                 busy,
  output logic                 overflow,
  output logic [31:0]          frame_count,
  output logic [31:0]          sample_count
);
  localparam int NUM_LANES = 2;
  localparam int DEPTH     = 1 << FIFO_DEPTH_LOG2;
  localparam logic [31:0] HDR_MAGIC  = 32'h46525354;
  localparam logic [31:0] TRL_MAGIC  = 32'h4C415354;
  localparam logic [31:0] ALIGN_MASK = (32'd1 << ALIGN_LOG2) - 32'd1;

  typedef enum logic [2:0] {
    S_IDLE, S_START_WAIT, S_HEADER, S_CAPTURE, S_STOP_WAIT, S_PAD, S_TRAILER
  } state_t;

  typedef struct packed {
    logic        last;
    logic        user;
    logic [63:0] data;
  } word_t;

  state_t                               r_state, w_state_n;
  logic                                 r_enable_d;
  logic [LAT_W-1:0]                     r_cnt, w_cnt_n;
  logic [31:0]                          r_word_cnt, w_wc_n;
  logic [31:0]                          r_sample_cnt, w_sc_n;
  logic [31:0]                          r_frame_cnt, w_fc_n;
  logic [31:0]                          r_gcnt;
  logic                                 r_overflow;
  logic                                 r_pad_en;
  logic [NUM_LANES-1:0][SEL_W-1:0]      r_sel;
  logic [NUM_LANES-1:0][31:0]           w_lane;

  word_t                                r_mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0]           r_wr_ptr, r_rd_ptr;
  logic [FIFO_DEPTH_LOG2:0]             r_fill;
  word_t                                w_head, w_wr_word;
  logic                                 w_empty, w_full, w_pop, w_space, w_push;
  logic                                 w_drop, w_start, w_aligned, w_pad_last;

  assign w_empty = (r_fill == '0);
  assign w_full  = (r_fill == (FIFO_DEPTH_LOG2+1)'(DEPTH));
  assign w_pop   = !w_empty && m_tready;
  // A pop in the same cycle frees the slot, so a full FIFO still takes a push.
  assign w_space = !w_full || w_pop;
  assign w_start = (r_state == S_IDLE) && enable && !r_enable_d;

  // (word_count+1) counts the trailer; aligned once that total hits the boundary.
  assign w_aligned  = ((r_word_cnt + 32'd1) & ALIGN_MASK) == 32'd0;
  assign w_pad_last = ((r_word_cnt + 32'd2) & ALIGN_MASK) == 32'd0;

  // Lane 1 is the upper 32 bits of each sample word, lane 0 the lower.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    radar_lane_mux #(.NUM_CH(NUM_CH), .SEL_W(SEL_W)) u_lane (
      .i_sel        (r_sel[l]),
      .i_ch_data    (ch_data),
      .i_sample_cnt (r_sample_cnt),
      .i_gcnt       (r_gcnt),
      .o_lane       (w_lane[l])
    );
  end

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_wc_n    = r_word_cnt;
    w_sc_n    = r_sample_cnt;
    w_fc_n    = r_frame_cnt;
    w_push    = 1'b0;
    w_drop    = 1'b0;
    w_wr_word = '0;

    // Sample path shared by CAPTURE and STOP_WAIT; dropped samples are not counted.
    if ((r_state == S_CAPTURE || r_state == S_STOP_WAIT) && ch_valid) begin
      if (w_space) begin
        w_push    = 1'b1;
        w_wr_word = '{last: 1'b0, user: 1'b0, data: {w_lane[1], w_lane[0]}};
        w_wc_n    = r_word_cnt + 32'd1;
        w_sc_n    = r_sample_cnt + 32'd1;
      end else begin
        w_drop = 1'b1;
      end
    end

    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_cnt_n   = start_delay;
          w_state_n = (start_delay == '0) ? S_HEADER : S_START_WAIT;
        end
      end
      S_START_WAIT: begin
        if (!enable)                    w_state_n = S_IDLE;
        else if (r_cnt <= LAT_W'(1))    w_state_n = S_HEADER;
        else                            w_cnt_n   = r_cnt - LAT_W'(1);
      end
      S_HEADER: begin
        if (w_space) begin
          w_push    = 1'b1;
          w_wr_word = '{last: 1'b0, user: 1'b1, data: {r_gcnt, HDR_MAGIC}};
          w_wc_n    = 32'd1;
          w_sc_n    = 32'd0;
          w_state_n = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (!enable) begin
          if (stop_delay != '0) begin
            w_cnt_n   = stop_delay;
            w_state_n = S_STOP_WAIT;
          end else begin
            w_state_n = r_pad_en ? S_PAD : S_TRAILER;
          end
        end
      end
      S_STOP_WAIT: begin
        if (r_cnt <= LAT_W'(1)) w_state_n = r_pad_en ? S_PAD : S_TRAILER;
        else                    w_cnt_n   = r_cnt - LAT_W'(1);
      end
      S_PAD: begin
        if (w_aligned) begin
          w_state_n = S_TRAILER;
        end else if (w_space) begin
          w_push = 1'b1;
          w_wc_n = r_word_cnt + 32'd1;
          if (w_pad_last) w_state_n = S_TRAILER;
        end
      end
      S_TRAILER: begin
        if (w_space) begin
          w_push    = 1'b1;
          w_wr_word = '{last: 1'b1, user: 1'b0, data: {r_gcnt, TRL_MAGIC}};
          w_fc_n    = r_frame_cnt + 32'd1;
          w_state_n = S_IDLE;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_enable_d   <= 1'b0;
      r_cnt        <= '0;
      r_word_cnt   <= '0;
      r_sample_cnt <= '0;
      r_frame_cnt  <= '0;
      r_gcnt       <= '0;
      r_overflow   <= 1'b0;
      r_pad_en     <= 1'b0;
      r_sel        <= '0;
    end else begin
      r_state      <= w_state_n;
      r_enable_d   <= enable;
      r_cnt        <= w_cnt_n;
      r_word_cnt   <= w_wc_n;
      r_sample_cnt <= w_sc_n;
      r_frame_cnt  <= w_fc_n;
      r_gcnt       <= r_gcnt + 32'd1;
      if (w_drop)            r_overflow <= 1'b1;
      else if (overflow_clr) r_overflow <= 1'b0;
      if (w_start) begin
        r_sel    <= {route_sel_u, route_sel_l};
        r_pad_en <= pad_enable;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_fill <= r_fill + (FIFO_DEPTH_LOG2+1)'(w_push) - (FIFO_DEPTH_LOG2+1)'(w_pop);
    end
  end

  // Storage is not reset; outputs are gated by empty so stale contents never show.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_wr_word;
  end

  assign w_head       = r_mem[r_rd_ptr];
  assign m_tvalid     = !w_empty;
  assign m_tdata      = w_empty ? 64'd0 : w_head.data;
  assign m_tlast      = !w_empty && w_head.last;
  assign m_tuser      = !w_empty && w_head.user;
  assign busy         = (r_state != S_IDLE);
  assign overflow     = r_overflow;
  assign frame_count  = r_frame_cnt;
  assign sample_count = r_sample_cnt;
endmodule

// File: tb/tb_radar_sample_framer.sv
// Directed bench for radar_sample_framer: latency, padding, overflow/backpressure,
// aborted start, routing latch and mid-frame reset.
module tb_radar_sample_framer;
  localparam int NUM_CH = 2, ALIGN_LOG2 = 4, LAT_W = 8, FDL = 4, SEL_W = 2;
  localparam logic [31:0] HDR = 32'h46525354, TRL = 32'h4C415354;

  logic               clk = 1'b0;
  logic               reset;
  logic [63:0]        ch_data;
  logic               ch_valid, enable, pad_enable, overflow_clr, m_tready;
  logic [LAT_W-1:0]   start_delay, stop_delay;
  logic [SEL_W-1:0]   route_sel_u, route_sel_l;
  logic [63:0]        m_tdata;
  logic               m_tvalid, m_tlast, m_tuser, busy, overflow;
  logic [31:0]        frame_count, sample_count;

  int checks = 0, errors = 0;
  int t = 0, qb = 0, saw;
  logic [65:0] q[$];
  logic [65:0] hw, tw;

  always #5 clk = ~clk;

  radar_sample_framer #(.NUM_CH(NUM_CH), .ALIGN_LOG2(ALIGN_LOG2), .LAT_W(LAT_W),
                        .FIFO_DEPTH_LOG2(FDL)) dut (
    .clk(clk), .reset(reset), .ch_data(ch_data), .ch_valid(ch_valid), .enable(enable),
    .start_delay(start_delay), .stop_delay(stop_delay), .route_sel_u(route_sel_u),
    .route_sel_l(route_sel_l), .pad_enable(pad_enable), .overflow_clr(overflow_clr),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tuser(m_tuser),
    .m_tready(m_tready), .busy(busy), .overflow(overflow), .frame_count(frame_count),
    .sample_count(sample_count));

  // Record every word popped from the stream as {tlast, tuser, tdata}.
  always @(negedge clk)
    if (!reset && m_tvalid && m_tready) q.push_back({m_tlast, m_tuser, m_tdata});

  function automatic logic [65:0] qw(input int i);
    if (qb + i < q.size()) return q[qb + i];
    return 'x;
  endfunction

  task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_t0();
    t = 0;
    ch_data = {32'hC0DE0000, 32'h55550000};
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      t++;
      ch_data = {32'hC0DE0000 + 32'(t), 32'h55550000 + 32'(t)};
    end
  endtask

  initial begin
    reset = 1'b1; ch_valid = 1'b1; enable = 1'b0; pad_enable = 1'b0; overflow_clr = 1'b0;
    m_tready = 1'b1; start_delay = 8'd4; stop_delay = 8'd2;
    route_sel_u = 2'd2; route_sel_l = 2'd1;
    set_t0();
    tick(3);
    chk("rst_tvalid", 66'(m_tvalid), 66'd0);
    chk("rst_tlast",  66'(m_tlast),  66'd0);
    chk("rst_tuser",  66'(m_tuser),  66'd0);
    chk("rst_tdata",  66'(m_tdata),  66'd0);
    chk("rst_busy",   66'(busy),     66'd0);
    chk("rst_ovf",    66'(overflow), 66'd0);
    chk("rst_fcnt",   66'(frame_count),  66'd0);
    chk("rst_scnt",   66'(sample_count), 66'd0);
    reset = 1'b0;
    tick(2);

    // Frame 1: start 4, stop 2, no pad; routes/pad changed mid-frame must be ignored.
    qb = q.size(); set_t0(); enable = 1'b1;
    tick(5);
    chk("f1_no_hdr_yet", 66'(m_tvalid), 66'd0);
    chk("f1_busy",       66'(busy),     66'd1);
    tick(1);
    chk("f1_hdr_vis",    66'({m_tvalid, m_tuser, m_tdata[31:0]}), 66'({2'b11, HDR}));
    route_sel_u = 2'd0; route_sel_l = 2'd3; pad_enable = 1'b1; start_delay = 8'd0;
    tick(4);
    enable = 1'b0;
    tick(12);
    chk("f1_nwords", 66'(q.size() - qb), 66'd9);
    chk("f1_w1",     qw(1), {2'b00, 32'd0, 32'hC0DE0006});
    chk("f1_w3",     qw(3), {2'b00, 32'd2, 32'hC0DE0008});
    chk("f1_w7",     qw(7), {2'b00, 32'd6, 32'hC0DE000C});
    hw = qw(0); tw = qw(8);
    chk("f1_hdr_flags", 66'({hw[65:64], hw[31:0]}), 66'({2'b01, HDR}));
    chk("f1_trl_flags", 66'({tw[65:64], tw[31:0]}), 66'({2'b10, TRL}));
    chk("f1_gcnt_span", 66'(tw[63:32] - hw[63:32]), 66'd8);
    chk("f1_fcnt", 66'(frame_count),  66'd1);
    chk("f1_scnt", 66'(sample_count), 66'd7);
    chk("f1_idle", 66'(busy), 66'd0);

    // Frame 2: same window with padding to 16 words.
    route_sel_u = 2'd2; route_sel_l = 2'd1; pad_enable = 1'b1; start_delay = 8'd4;
    qb = q.size(); set_t0(); enable = 1'b1;
    tick(10);
    enable = 1'b0;
    tick(20);
    chk("f2_nwords", 66'(q.size() - qb), 66'd16);
    chk("f2_w7",     qw(7),  {2'b00, 32'd6, 32'hC0DE000C});
    chk("f2_pad8",   qw(8),  66'd0);
    chk("f2_pad14",  qw(14), 66'd0);
    tw = qw(15);
    chk("f2_trl",    66'({tw[65:64], tw[31:0]}), 66'({2'b10, TRL}));
    chk("f2_fcnt",   66'(frame_count), 66'd2);

    // Frame 3: FIFO fills under backpressure; set beats clear; trailer still delivered.
    pad_enable = 1'b0; start_delay = 8'd0; stop_delay = 8'd0; m_tready = 1'b0;
    qb = q.size(); set_t0(); enable = 1'b1;
    tick(35);
    overflow_clr = 1'b1;
    tick(5);
    chk("f3_ovf_set_wins", 66'(overflow), 66'd1);
    chk("f3_scnt",         66'(sample_count), 66'd15);
    enable = 1'b0; overflow_clr = 1'b0;
    tick(3);
    chk("f3_stalled_busy", 66'(busy), 66'd1);
    chk("f3_head_is_hdr",  66'(m_tuser), 66'd1);
    m_tready = 1'b1;
    tick(25);
    chk("f3_nwords", 66'(q.size() - qb), 66'd17);
    chk("f3_w15",    qw(15), {2'b00, 32'd14, 32'hC0DE0010});
    tw = qw(16);
    chk("f3_trl",    66'({tw[65:64], tw[31:0]}), 66'({2'b10, TRL}));
    chk("f3_fcnt",   66'(frame_count), 66'd3);
    chk("f3_ovf_sticky", 66'(overflow), 66'd1);
    overflow_clr = 1'b1; tick(1); overflow_clr = 1'b0; tick(1);
    chk("f3_ovf_clr", 66'(overflow), 66'd0);

    // Aborted start: 2-cycle pulse with start_delay 5 writes nothing.
    start_delay = 8'd5;
    qb = q.size(); set_t0(); enable = 1'b1;
    tick(1);
    chk("ab_busy", 66'(busy), 66'd1);
    tick(1);
    enable = 1'b0;
    tick(1);
    chk("ab_idle", 66'(busy), 66'd0);
    saw = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (m_tvalid) saw++;
    end
    chk("ab_no_tvalid", 66'(saw), 66'd0);
    chk("ab_nwords",    66'(q.size() - qb), 66'd0);
    chk("ab_fcnt",      66'(frame_count), 66'd3);

    // Reset during CAPTURE, then a clean frame (start 1, stop 1).
    start_delay = 8'd0; m_tready = 1'b0; set_t0(); enable = 1'b1;
    tick(5);
    chk("rc_pre_tvalid", 66'(m_tvalid), 66'd1);
    reset = 1'b1; enable = 1'b0;
    tick(1);
    chk("rc_tvalid", 66'(m_tvalid), 66'd0);
    chk("rc_tdata",  66'(m_tdata),  66'd0);
    chk("rc_busy",   66'(busy),     66'd0);
    chk("rc_fcnt",   66'(frame_count), 66'd0);
    reset = 1'b0; m_tready = 1'b1; start_delay = 8'd1; stop_delay = 8'd1;
    qb = q.size(); set_t0(); enable = 1'b1;
    tick(5);
    enable = 1'b0;
    tick(10);
    chk("rc_nwords", 66'(q.size() - qb), 66'd6);
    chk("rc_hdr",    qw(0), {2'b01, 32'd2, HDR});
    chk("rc_w1",     qw(1), {2'b00, 32'd0, 32'hC0DE0003});
    chk("rc_w4",     qw(4), {2'b00, 32'd3, 32'hC0DE0006});
    chk("rc_trl",    qw(5), {2'b10, 32'd7, TRL});
    chk("rc_fcnt",   66'(frame_count),  66'd1);
    chk("rc_scnt",   66'(sample_count), 66'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
